fan_tach_capture: RTL and testbench
===================================

# fan_tach_capture

Fan-tachometer reader that produces the controller's process value. It measures the period of the fan tach signal in 10 MHz clock-enable ticks and converts it to a saturated speed value using a sequential divider. It then presents the result on the same value/strobe data interface the fan controller consumes for its ADC input. The block sits between the fan's tach pin and the fan-control core, closing the loop opposite the PWM output.

## Interface
- ADC_BITWIDTH, 8: width of speed output.
- CNT_BITWIDTH, 20: width of period counter; also sets the stall timeout.
- FILTER_LEN, 4: consecutive equal samples needed to accept a tach level change.
- SPEED_SCALE, 25_500_000: dividend; speed = SPEED_SCALE / period.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- clk_en_i  input  1  10 MHz sampling/count enable.
- tach_i  input  1  raw open-collector tach pin, asynchronous.
- config_en_i  input  1  controller in config mode; suppresses strobe.
- ADC_value_o  output  ADC_BITWIDTH  latest speed value.
- dataVaild_STRB_o  output  1  one-cycle strobe, ADC_value_o valid.
- stall_o  output  1  no tach edge within timeout.

## Operation
- tach_i passes through a 2-FF synchronizer on clk_i.
- Glitch filter:
  - The synchronizer output is sampled only on clk_en_i ticks.
  - The filtered level changes after FILTER_LEN consecutive ticks that differ from it.
  - The filtered level resets to 0.
- Event: a 0->1 transition of the filtered level.
- Period counter:
  - Cleared to 0 on an event tick.
  - Otherwise increments on each clk_en_i tick.
  - Saturates at 2^CNT_BITWIDTH-1.
- FSM states: ARM, MEASURE, DIVIDE.
  - ARM (reset state): the first event moves to MEASURE. No output.
  - MEASURE, event: latch period = counter+1 (ticks between events), then go to DIVIDE.
  - MEASURE, counter reaches saturation: ADC_value_o <= 0, pulse the strobe, set stall_o, go to ARM.
  - DIVIDE: restoring divider runs one step per clk_i cycle, independent of clk_en_i, for DIV_STEPS = CNT_BITWIDTH+ADC_BITWIDTH cycles.
    - Quotient = floor(SPEED_SCALE/period).
    - If the quotient is > 2^ADC_BITWIDTH-1, saturate to all ones.
    - On completion, load ADC_value_o, pulse the strobe, return to MEASURE.
- Event while in DIVIDE:
  - The counter restarts as usual.
  - The pending division completes and is reported.
  - The new interval is measured from that event. Nothing is lost, because the counter runs concurrently.
- stall_o clears on the first event after a stall.
- config_en_i=1 at strobe time:
  - ADC_value_o still updates.
  - dataVaild_STRB_o stays 0.
- Width rules:
  - Divider remainder register is CNT_BITWIDTH+1 bits.
  - Dividend register is DIV_STEPS bits.
  - SPEED_SCALE must fit in DIV_STEPS bits.

## Timing
- Reset values: ADC_value_o=0, dataVaild_STRB_o=0, stall_o=0, FSM=ARM, counter=0, filter level=0.
- Input to filtered level: 2 clk_i (sync) + FILTER_LEN clk_en_i ticks.
- Event tick to strobe: exactly DIV_STEPS+1 clk_i cycles.
  - The period is latched in the event cycle.
  - ADC_value_o changes in the same cycle the strobe is high and holds until the next update.
- dataVaild_STRB_o is high for exactly one clk_i cycle, never two consecutive cycles.
- Timeout strobe occurs in the cycle after the counter reaches saturation.
- stall_o rises with the timeout strobe and falls one cycle after the next event.
- rstn_i low mid-DIVIDE:
  - The division is abandoned and no strobe is issued.
  - All state returns to reset values immediately (asynchronously).
- clk_en_i held low: the counter and filter freeze. A DIVIDE already in progress still completes.

## Test plan
- Square wave, 100_000-tick period, clk_en_i every cycle:
  - No strobe after the first rising edge.
  - Then ADC_value_o=255 with one strobe per period.
  - Each strobe occurs 29 cycles after the event.
- 200_000-tick period -> ADC_value_o=127 each strobe. 50_000-tick period (quotient 510) -> saturates to 255.
- 2-tick and 3-tick high glitches on a low tach_i -> no event, no strobe. A 4-tick high pulse followed by a later valid edge -> accepted as an event.
- tach_i stuck low after lock:
  - 1_048_575 ticks after the last event -> ADC_value_o=0, one strobe, stall_o=1, FSM in ARM.
  - Resumed 100_000-tick wave -> stall_o=0; the first valid strobe gives 255.
- config_en_i=1 through a measurement -> ADC_value_o updates to 255, dataVaild_STRB_o never asserts.
- rstn_i pulsed low 10 cycles into DIVIDE -> no strobe, all outputs 0. The next two events give a correct value.

Source files
------------

// File: rtl/fan_tach_capture.sv
// Fan tach reader: synchronises and deglitches the tach pin, measures the period in clk_en_i ticks
// and reports SPEED_SCALE/period, saturated, on the controller's value/strobe interface.
module fan_tach_capture #(
    parameter int unsigned ADC_BITWIDTH = 8,
    parameter int unsigned CNT_BITWIDTH = 20,
    parameter int unsigned FILTER_LEN   = 4,
    parameter int unsigned SPEED_SCALE  = 25_500_000
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    tach_i,
    input  logic                    config_en_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    stall_o
);

    localparam int unsigned DIV_STEPS = CNT_BITWIDTH + ADC_BITWIDTH;
    localparam int unsigned FW        = $clog2(FILTER_LEN + 1);
    localparam int unsigned SW        = $clog2(DIV_STEPS + 1);
    localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic                    filt_q, filt_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_BITWIDTH:0]   period_q, period_d;
    logic [CNT_BITWIDTH:0]   rem_q, rem_d;
    logic [DIV_STEPS-1:0]    dvd_q, dvd_d;
    logic [SW-1:0]           step_q, step_d;
    logic [ADC_BITWIDTH-1:0] value_q, value_d;
    logic                    strb_q, strb_d;
    logic                    stall_q, stall_d;

    logic                    event_c;
    logic [CNT_BITWIDTH+1:0] shl_c;
    logic                    ge_c;
    logic [CNT_BITWIDTH:0]   rem_step_c;
    logic [DIV_STEPS-1:0]    quot_c;
    logic [ADC_BITWIDTH-1:0] sat_c;

    // Synchroniser, glitch filter and free-running period counter
    always_comb begin
        sync_d = {sync_q[0], tach_i};
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_en_i) begin
            if (sync_q[1] != filt_q) begin
                if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_d = sync_q[1];
                    fcnt_d = '0;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end else begin
                fcnt_d = '0;
            end
        end
        event_c = filt_d & ~filt_q;

        cnt_d = cnt_q;
        if (event_c) begin
            cnt_d = '0;
        end else if (clk_en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_BITWIDTH'(1);
        end
    end

    // One restoring-division step: the dividend register shifts out its MSB and collects quotient bits
    always_comb begin
        shl_c      = {rem_q, dvd_q[DIV_STEPS-1]};
        ge_c       = (shl_c >= {1'b0, period_q});
        rem_step_c = ge_c ? (CNT_BITWIDTH+1)'(shl_c - {1'b0, period_q})
                          : (CNT_BITWIDTH+1)'(shl_c);
        quot_c     = {dvd_q[DIV_STEPS-2:0], ge_c};
        sat_c      = (|quot_c[DIV_STEPS-1:ADC_BITWIDTH]) ? '1 : quot_c[ADC_BITWIDTH-1:0];
    end

    // Measurement FSM
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        step_d   = step_q;
        value_d  = value_q;
        strb_d   = 1'b0;
        stall_d  = stall_q;
        if (event_c) begin
            stall_d = 1'b0;
        end
        case (state_q)
            ARM: begin
                if (event_c) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (event_c) begin
                    period_d = {1'b0, cnt_q} + (CNT_BITWIDTH+1)'(1);
                    rem_d    = '0;
                    dvd_d    = DIV_STEPS'(SPEED_SCALE);
                    step_d   = '0;
                    state_d  = DIVIDE;
                end else if (cnt_q == CNT_MAX) begin
                    value_d = '0;
                    strb_d  = ~config_en_i;
                    stall_d = 1'b1;
                    state_d = ARM;
                end
            end
            DIVIDE: begin
                rem_d  = rem_step_c;
                dvd_d  = quot_c;
                step_d = step_q + SW'(1);
                if (step_q == SW'(DIV_STEPS - 1)) begin
                    value_d = sat_c;
                    strb_d  = ~config_en_i;
                    state_d = MEASURE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ARM;
            sync_q   <= '0;
            filt_q   <= 1'b0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            step_q   <= '0;
            value_q  <= '0;
            strb_q   <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            step_q   <= step_d;
            value_q  <= value_d;
            strb_q   <= strb_d;
            stall_q  <= stall_d;
        end
    end

    assign ADC_value_o      = value_q;
    assign dataVaild_STRB_o = strb_q;
    assign stall_o          = stall_q;

endmodule

// File: tb/tb_fan_tach_capture.sv
// Bench for fan_tach_capture, scaled down (12-bit counter, SPEED_SCALE 25_500) so that
// 100/200/50-tick periods give 255/127/saturated and the stall timeout comes after 4095 ticks.
module tb_fan_tach_capture;

    localparam int unsigned ADC_W  = 8;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned FLEN   = 4;
    localparam int unsigned SCALE  = 25_500;
    localparam int DSTEPS    = CNT_W + ADC_W;
    localparam int LAT       = 2 + FLEN + DSTEPS;        // tach rise drive -> strobe visible
    localparam int STALL_LAT = 2 + FLEN + (1 << CNT_W);  // last tach rise -> timeout strobe
    localparam int MAXV      = (1 << ADC_W) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             clk_en;
    logic             tach;
    logic             cfg;
    logic [ADC_W-1:0] val;
    logic             strb;
    logic             stall;

    fan_tach_capture #(
        .ADC_BITWIDTH(ADC_W),
        .CNT_BITWIDTH(CNT_W),
        .FILTER_LEN  (FLEN),
        .SPEED_SCALE (SCALE)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .clk_en_i        (clk_en),
        .tach_i          (tach),
        .config_en_i     (cfg),
        .ADC_value_o     (val),
        .dataVaild_STRB_o(strb),
        .stall_o         (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int value;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;
    int   last_rise = 0;
    bit   have_last = 1'b0;
    bit   push_en = 1'b1;
    bit   prev_strb = 1'b0;

    function automatic int exp_speed(input int period);
        int q;
        q = int'(SCALE) / period;
        return (q > MAXV) ? MAXV : q;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise_edge();
        exp_t e;
        tach = 1'b1;
        if (have_last && push_en) begin
            e.value = exp_speed(cyc - last_rise);
            e.due   = cyc + LAT;
            sb.push_back(e);
        end
        last_rise = cyc;
        have_last = 1'b1;
    endtask

    task automatic wave(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            rise_edge();
            step(high);
            tach = 1'b0;
            step(period - high);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; tach = 1'b0; clk_en = 1'b1; cfg = 1'b0;
        step(3);
        checks++; if (val !== '0) begin failures++; $display("FAIL reset_value got=%0d want=0", val); end
        checks++; if (strb !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b want=0", strb); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
        rstn = 1'b1;
        step(2);
    endtask

    task automatic test_speed_100();
        int s0 = strobes;
        wave(100, 50, 1);
        checks++; if (strobes != s0) begin failures++; $display("FAIL first_edge_no_strobe got=%0d want=%0d", strobes, s0); end
        wave(100, 50, 3);
        checks++; if (strobes != s0 + 3) begin failures++; $display("FAIL speed100_count got=%0d want=%0d", strobes, s0 + 3); end
        checks++; if (val !== ADC_W'(255)) begin failures++; $display("FAIL speed100_value got=%0d want=255", val); end
    endtask

    task automatic test_speed_200();
        int s0 = strobes;
        wave(200, 100, 3);
        checks++; if (strobes != s0 + 3) begin failures++; $display("FAIL speed200_count got=%0d want=%0d", strobes, s0 + 3); end
        checks++; if (val !== ADC_W'(127)) begin failures++; $display("FAIL speed200_value got=%0d want=127", val); end
    endtask

    task automatic test_speed_50();
        int s0 = strobes;
        wave(50, 25, 4);
        checks++; if (strobes != s0 + 4) begin failures++; $display("FAIL speed50_count got=%0d want=%0d", strobes, s0 + 4); end
        checks++; if (val !== ADC_W'(255)) begin failures++; $display("FAIL speed50_saturate got=%0d want=255", val); end
    endtask

    task automatic test_stall();
        int   s0 = strobes;
        exp_t e;
        e.value = 0;
        e.due   = last_rise + STALL_LAT;
        sb.push_back(e);
        have_last = 1'b0;
        for (int i = 0; i < STALL_LAT + 100 && strobes == s0; i++) step(1);
        checks++; if (strobes != s0 + 1) begin failures++; $display("FAIL timeout_strobe got=%0d want=%0d", strobes, s0 + 1); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_set got=%b want=1", stall); end
        checks++; if (val !== '0) begin failures++; $display("FAIL stall_value got=%0d want=0", val); end
        step(200);
        checks++; if (strobes != s0 + 1) begin failures++; $display("FAIL stall_single_strobe got=%0d want=%0d", strobes, s0 + 1); end
    endtask

    task automatic test_glitch();
        int s0 = strobes;
        tach = 1'b1; step(2); tach = 1'b0; step(30);
        tach = 1'b1; step(3); tach = 1'b0; step(60);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL glitch_ignored got_stall=%b want=1", stall); end
        rise_edge(); step(4); tach = 1'b0; step(10);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL pulse_event_clears_stall got=%b want=0", stall); end
        step(86);
        wave(100, 50, 3);
        checks++; if (strobes != s0 + 3) begin failures++; $display("FAIL resume_count got=%0d want=%0d", strobes, s0 + 3); end
        checks++; if (val !== ADC_W'(255)) begin failures++; $display("FAIL resume_value got=%0d want=255", val); end
    endtask

    task automatic test_config();
        int s0 = strobes;
        cfg = 1'b1; push_en = 1'b0;
        wave(200, 100, 3);
        cfg = 1'b0; push_en = 1'b1;
        checks++; if (strobes != s0) begin failures++; $display("FAIL config_no_strobe got=%0d want=%0d", strobes, s0); end
        checks++; if (val !== ADC_W'(127)) begin failures++; $display("FAIL config_value got=%0d want=127", val); end
    endtask

    task automatic test_reset_mid_divide();
        int s0 = strobes;
        push_en = 1'b0;
        rise_edge(); step(10); tach = 1'b0; step(6);
        rstn = 1'b0;
        #1;
        checks++; if (val !== '0) begin failures++; $display("FAIL async_reset_value got=%0d want=0", val); end
        step(4);
        checks++; if ({strb, stall} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {strb, stall}); end
        rstn = 1'b1; have_last = 1'b0; push_en = 1'b1;
        step(50);
        checks++; if (strobes != s0) begin failures++; $display("FAIL aborted_divide_strobe got=%0d want=%0d", strobes, s0); end
        wave(100, 50, 3);
        checks++; if (strobes != s0 + 2) begin failures++; $display("FAIL post_reset_count got=%0d want=%0d", strobes, s0 + 2); end
        checks++; if (val !== ADC_W'(255)) begin failures++; $display("FAIL post_reset_value got=%0d want=255", val); end
    endtask

    initial begin
        rstn = 1'b0; tach = 1'b0; clk_en = 1'b1; cfg = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (strb === 1'b1) begin
                    strobes++;
                    checks++;
                    if (prev_strb) begin failures++; $display("FAIL strobe_width two consecutive strobes at cycle %0d", cyc); end
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_strobe value=%0d cycle=%0d want=no strobe", val, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        checks++;
                        if (val !== ADC_W'(mon_e.value)) begin
                            failures++; $display("FAIL strobe_value got=%0d want=%0d", val, mon_e.value);
                        end
                        checks++;
                        if (cyc != mon_e.due) begin
                            failures++; $display("FAIL strobe_latency got_cycle=%0d want_cycle=%0d", cyc, mon_e.due);
                        end
                    end
                end
                prev_strb = (strb === 1'b1);
            end
        join_none

        test_reset();
        test_speed_100();
        test_speed_200();
        test_speed_50();
        test_stall();
        test_glitch();
        test_config();
        test_reset_mid_divide();
        step(LAT + 5);
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL pending_strobes got=%0d want=0", sb.size()); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
